// File: rtl/ram_port_initiator_if.sv
// Request, response and RAM-port signals of ram_port_initiator.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// valid must not depend on ready, and the payload is held while valid is 1 and ready is 0.
interface ram_port_initiator_if #(
    parameter int BYTES  = 4,
    parameter int AWIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AWIDTH-1:0]    req_addr;
    logic [BYTES-1:0]     req_be;
    logic [BYTES*8-1:0]   req_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BYTES*8-1:0]   rsp_rdata;
    logic                 rsp_err;

    logic [AWIDTH-1:0]    ram_address;
    logic                 ram_ce;
    logic                 ram_we;
    logic [BYTES-1:0]     ram_be;
    logic [BYTES*8-1:0]   ram_d;
    logic [BYTES*8-1:0]   ram_q;

    modport master (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        input  rsp_ready, ram_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_address, ram_ce, ram_we, ram_be, ram_d
    );

    modport slave (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        output rsp_ready, ram_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_address, ram_ce, ram_we, ram_be, ram_d
    );
endinterface

// File: rtl/ram_port_initiator.sv
// Drives one port of a byte-enabled synchronous RAM from a request stream and returns
// read data through a credit-protected response FIFO.
module ram_port_initiator #(
    parameter int BYTES     = 4,
    parameter int DEPTH     = 256,
    parameter int AWIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_initiator_if.master  bus
);
    localparam int W  = BYTES * 8;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [AWIDTH:0] DEPTH_LIM  = (AWIDTH + 1)'(DEPTH);
    localparam logic [CW:0]     CREDIT_LIM = (CW + 1)'(RSP_DEPTH);

    // Stage C: command register, directly drives the RAM port
    logic [AWIDTH-1:0] cmd_address;
    logic              cmd_ce;
    logic              cmd_we;
    logic [BYTES-1:0]  cmd_be;
    logic [W-1:0]      cmd_d;
    logic              cmd_rd;
    logic              cmd_err;

    // Stage P: read whose data is on ram_q this cycle
    logic              pend_rd;
    logic              pend_err;

    // Response FIFO, entry = {err, data}
    logic [W:0]        fifo_mem [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;

    logic              accept;
    logic              in_range;
    logic              push;
    logic              pop;
    logic [W:0]        push_entry;
    logic [W:0]        head;
    logic [CW:0]       credits_used;
    logic              req_ready;

    // Every read holds a slot from acceptance until it leaves the FIFO
    assign credits_used = {1'b0, fifo_count}
                        + {{CW{1'b0}}, cmd_rd}
                        + {{CW{1'b0}}, pend_rd};
    assign req_ready    = (credits_used < CREDIT_LIM);

    assign accept     = bus.req_valid & req_ready;
    assign in_range   = ({1'b0, bus.req_addr} < DEPTH_LIM);

    assign push       = pend_rd;
    assign pop        = (fifo_count != '0) & bus.rsp_ready;
    assign push_entry = pend_err ? {1'b1, {W{1'b0}}} : {1'b0, bus.ram_q};
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_address <= '0;
            cmd_ce      <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_be      <= '0;
            cmd_d       <= '0;
            cmd_rd      <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_rd  <= accept & ~bus.req_we;
            cmd_err <= accept & ~bus.req_we & ~in_range;
            if (accept) begin
                cmd_address <= bus.req_addr;
                cmd_ce      <= in_range;
                cmd_we      <= bus.req_we;
                cmd_be      <= bus.req_be;
                cmd_d       <= bus.req_wdata;
            end else begin
                cmd_ce <= 1'b0;
                cmd_we <= 1'b0;
                cmd_be <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd  <= 1'b0;
            pend_err <= 1'b0;
        end else begin
            pend_rd  <= cmd_rd;
            pend_err <= cmd_err;
        end
    end

    // Storage needs no reset: fifo_count gates everything read from it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = (fifo_count != '0);
    assign bus.rsp_rdata   = (fifo_count != '0) ? head[W-1:0] : '0;
    assign bus.rsp_err     = (fifo_count != '0) & head[W];

    assign bus.ram_address = cmd_address;
    assign bus.ram_ce      = cmd_ce;
    assign bus.ram_we      = cmd_we;
    assign bus.ram_be      = cmd_be;
    assign bus.ram_d       = cmd_d;
endmodule
